// File: rtl/pc_sequencer.sv
// Program-counter sequencer: INIT/FETCH/EXEC/INTR control FSM that drives the
// PC mux/load/increment, stack and SP strobes, and owns IE and the interrupt-pending flag.
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | hold PC at zero for INIT_CYCLES cycles after reset release
// FETCH | increment PC and load the instruction register
// EXEC  | decode branch/call/return requests into PC and stack strobes
// INTR  | push return address, vector to 0x3FF, clear IE and pending
module pc_sequencer #(
  parameter int INTR_LATCH  = 1,
  parameter int INIT_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       JMP_REQ,
  input  logic       COND,
  input  logic       CALL_REQ,
  input  logic       RET_REQ,
  input  logic       RETI_REQ,
  input  logic       SEI,
  input  logic       CLI,
  input  logic       INTR,
  output logic       PC_LD,
  output logic       PC_INC,
  output logic [1:0] PC_MUX_SEL,
  output logic       IR_LD,
  output logic       STACK_WE,
  output logic       SP_DECR,
  output logic       SP_INCR,
  output logic       IE_OUT,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_INTR  = 2'd3
  } state_e;

  localparam logic [1:0] SEL_IMM   = 2'd0;
  localparam logic [1:0] SEL_STACK = 2'd1;
  localparam logic [1:0] SEL_VEC   = 2'd2;
  localparam logic [1:0] SEL_ZERO  = 2'd3;
  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] init_cnt_q, init_cnt_d;
  logic       ie_q, ie_d;
  logic       ie_next;
  logic       pend_eff;

  logic       pc_ld, pc_inc, ir_ld, stack_we, sp_decr, sp_incr;
  logic [1:0] mux_sel;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      ie_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ie_q       <= ie_d;
    end
  end

  generate
    if (INTR_LATCH != 0) begin : g_latch
      logic pend_q, pend_d;

      // A new request in the INTR cycle outlives the clear; IE=0 masks it.
      always_comb begin
        pend_d = pend_q;
        if (state_q == S_INTR) pend_d = 1'b0;
        if (INTR)              pend_d = 1'b1;
      end

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) pend_q <= 1'b0;
        else     pend_q <= pend_d;
      end

      assign pend_eff = pend_q;
    end else begin : g_level
      assign pend_eff = INTR;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ie_d       = ie_q;
    ie_next    = ie_q;
    pc_ld      = 1'b0;
    pc_inc     = 1'b0;
    mux_sel    = SEL_IMM;
    ir_ld      = 1'b0;
    stack_we   = 1'b0;
    sp_decr    = 1'b0;
    sp_incr    = 1'b0;

    case (state_q)
      S_INIT: begin
        pc_ld   = 1'b1;
        mux_sel = SEL_ZERO;
        if (init_cnt_q == INIT_LAST) begin
          init_cnt_d = '0;
          state_d    = S_FETCH;
        end else begin
          init_cnt_d = init_cnt_q + 4'd1;
        end
      end

      S_FETCH: begin
        pc_inc  = 1'b1;
        ir_ld   = 1'b1;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        if (RETI_REQ || RET_REQ) begin
          pc_ld   = 1'b1;
          mux_sel = SEL_STACK;
          sp_incr = 1'b1;
        end else if (CALL_REQ) begin
          pc_ld    = 1'b1;
          mux_sel  = SEL_IMM;
          stack_we = 1'b1;
          sp_decr  = 1'b1;
        end else if (JMP_REQ && COND) begin
          pc_ld   = 1'b1;
          mux_sel = SEL_IMM;
        end

        if (CLI)                 ie_next = 1'b0;
        else if (SEI || RETI_REQ) ie_next = 1'b1;
        ie_d = ie_next;

        // Deciding on ie_next lets SEI open and CLI close the window in the same instruction.
        if (ie_next && (pend_eff || INTR)) state_d = S_INTR;
        else                               state_d = S_FETCH;
      end

      S_INTR: begin
        pc_ld    = 1'b1;
        mux_sel  = SEL_VEC;
        stack_we = 1'b1;
        sp_decr  = 1'b1;
        ie_d     = 1'b0;
        state_d  = S_FETCH;
      end

      default: state_d = S_INIT;
    endcase
  end

  // Reset also masks the strobes combinationally so an aborted instruction leaves no trace.
  assign PC_LD      = pc_ld    & ~RST;
  assign PC_INC     = pc_inc   & ~RST;
  assign PC_MUX_SEL = RST ? SEL_IMM : mux_sel;
  assign IR_LD      = ir_ld    & ~RST;
  assign STACK_WE   = stack_we & ~RST;
  assign SP_DECR    = sp_decr  & ~RST;
  assign SP_INCR    = sp_incr  & ~RST;
  assign IE_OUT     = ie_q;
  assign STATE      = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: two configurations driven in parallel, expectations
// from a per-cycle behavioural model pushed to queues and checked by an independent monitor.
module tb_pc_sequencer;

  localparam logic [7:0] R_JMP  = 8'h80;
  localparam logic [7:0] R_COND = 8'h40;
  localparam logic [7:0] R_CALL = 8'h20;
  localparam logic [7:0] R_RET  = 8'h10;
  localparam logic [7:0] R_RETI = 8'h08;
  localparam logic [7:0] R_SEI  = 8'h04;
  localparam logic [7:0] R_CLI  = 8'h02;
  localparam logic [7:0] R_INTR = 8'h01;

  typedef struct packed {
    logic [31:0] cyc;
    logic [10:0] v;
  } exp_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST = 1'b1;
  logic JMP_REQ = 0, COND = 0, CALL_REQ = 0, RET_REQ = 0, RETI_REQ = 0;
  logic SEI = 0, CLI = 0, INTR = 0;

  logic       a_ld, a_inc, a_ir, a_we, a_spd, a_spi, a_ie;
  logic [1:0] a_sel, a_st;
  logic       b_ld, b_inc, b_ir, b_we, b_spd, b_spi, b_ie;
  logic [1:0] b_sel, b_st;

  pc_sequencer #(.INTR_LATCH(1), .INIT_CYCLES(1)) dut_a (
    .CLK(CLK), .RST(RST), .JMP_REQ(JMP_REQ), .COND(COND), .CALL_REQ(CALL_REQ),
    .RET_REQ(RET_REQ), .RETI_REQ(RETI_REQ), .SEI(SEI), .CLI(CLI), .INTR(INTR),
    .PC_LD(a_ld), .PC_INC(a_inc), .PC_MUX_SEL(a_sel), .IR_LD(a_ir),
    .STACK_WE(a_we), .SP_DECR(a_spd), .SP_INCR(a_spi), .IE_OUT(a_ie), .STATE(a_st)
  );

  pc_sequencer #(.INTR_LATCH(0), .INIT_CYCLES(3)) dut_b (
    .CLK(CLK), .RST(RST), .JMP_REQ(JMP_REQ), .COND(COND), .CALL_REQ(CALL_REQ),
    .RET_REQ(RET_REQ), .RETI_REQ(RETI_REQ), .SEI(SEI), .CLI(CLI), .INTR(INTR),
    .PC_LD(b_ld), .PC_INC(b_inc), .PC_MUX_SEL(b_sel), .IR_LD(b_ir),
    .STACK_WE(b_we), .SP_DECR(b_spd), .SP_INCR(b_spi), .IE_OUT(b_ie), .STATE(b_st)
  );

  logic [10:0] act_a, act_b;
  assign act_a = {a_ld, a_inc, a_sel, a_ir, a_we, a_spd, a_spi, a_ie, a_st};
  assign act_b = {b_ld, b_inc, b_sel, b_ir, b_we, b_spd, b_spi, b_ie, b_st};

  exp_t q_a[$];
  exp_t q_b[$];
  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;

  // Reference model: phase 0..3 as the STATE output, remaining INIT cycles, IE, pending.
  int m_latch[2] = '{1, 0};
  int m_initc[2] = '{1, 3};
  int m_phase[2];
  int m_left[2];
  bit m_ie[2];
  bit m_pend[2];

  task automatic model_step(input int k, input bit rst, input logic [7:0] req,
                            output logic [10:0] e);
    bit jmp, cnd, call, ret, reti, sei, cli, intr;
    bit ld, inc, ir, we, spd, spi, ie_n, take, pend_now;
    int sel, nxt;
    {jmp, cnd, call, ret, reti, sei, cli, intr} = req;
    ld = 0; inc = 0; ir = 0; we = 0; spd = 0; spi = 0; sel = 0;
    if (rst) begin
      e = '0;
      m_phase[k] = 0; m_ie[k] = 0; m_pend[k] = 0; m_left[k] = m_initc[k];
      return;
    end
    nxt = m_phase[k];
    ie_n = m_ie[k];
    pend_now = (m_latch[k] != 0) ? m_pend[k] : intr;
    if (m_phase[k] == 0) begin
      ld = 1; sel = 3;
      m_left[k] = m_left[k] - 1;
      if (m_left[k] == 0) nxt = 1;
    end else if (m_phase[k] == 1) begin
      inc = 1; ir = 1; nxt = 2;
    end else if (m_phase[k] == 2) begin
      if (reti || ret)      begin ld = 1; sel = 1; spi = 1; end
      else if (call)        begin ld = 1; sel = 0; we = 1; spd = 1; end
      else if (jmp && cnd)  begin ld = 1; sel = 0; end
      if (cli) ie_n = 0;
      else if (sei || reti) ie_n = 1;
      take = ie_n && (pend_now || intr);
      nxt = take ? 3 : 1;
    end else begin
      ld = 1; sel = 2; we = 1; spd = 1; ie_n = 0; nxt = 1;
    end
    e = {ld, inc, sel[1:0], ir, we, spd, spi, m_ie[k], m_phase[k][1:0]};
    if (m_latch[k] != 0) begin
      if (intr) m_pend[k] = 1;
      else if (m_phase[k] == 3) m_pend[k] = 0;
    end
    m_ie[k] = ie_n;
    m_phase[k] = nxt;
  endtask

  task automatic drive(input bit rst, input bit mid, input logic [7:0] req);
    logic [10:0] e;
    @(posedge CLK);
    #1;
    {JMP_REQ, COND, CALL_REQ, RET_REQ, RETI_REQ, SEI, CLI, INTR} = req;
    if (!rst)     RST = 1'b0;
    else if (!mid) RST = 1'b1;
    model_step(0, rst, req, e);
    q_a.push_back('{cyc: cyc, v: e});
    model_step(1, rst, req, e);
    q_b.push_back('{cyc: cyc, v: e});
    if (rst && mid) begin
      #2;
      RST = 1'b1;
    end
    cyc++;
  endtask

  task automatic idle_until(input int phase);
    for (int i = 0; i < 20 && m_phase[0] != phase; i++) drive(0, 0, 8'h00);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        tests++;
        if (act_a !== e.v) begin
          failed++;
          $display("FAIL outputs_latch1 cyc=%0d got=%b expected=%b", e.cyc, act_a, e.v);
        end
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        tests++;
        if (act_b !== e.v) begin
          failed++;
          $display("FAIL outputs_latch0 cyc=%0d got=%b expected=%b", e.cyc, act_b, e.v);
        end
      end
    end
  end

  initial begin : stimulus
    bit          r, mid;
    logic [7:0]  req;
    drive(1, 0, 8'h00);
    drive(1, 0, 8'h00);
    for (int i = 0; i < 6; i++) drive(0, 0, 8'h00);

    idle_until(2); drive(0, 0, R_JMP | R_COND);
    idle_until(2); drive(0, 0, R_JMP);
    idle_until(2); drive(0, 0, R_CALL | R_RET);

    idle_until(2); drive(0, 0, R_SEI);
    idle_until(1); drive(0, 0, R_INTR);
    drive(0, 0, 8'h00);
    drive(0, 0, 8'h00);
    drive(0, 0, 8'h00);

    idle_until(2); drive(0, 0, R_SEI);
    idle_until(1); drive(0, 0, R_INTR);
    drive(0, 0, R_CLI | R_SEI);
    idle_until(2); drive(0, 0, R_SEI);
    drive(0, 0, 8'h00);
    drive(0, 0, 8'h00);

    idle_until(1); drive(0, 0, R_INTR);
    drive(0, 0, 8'h00);
    idle_until(2); drive(0, 0, R_RETI);
    drive(0, 0, 8'h00);
    drive(0, 0, 8'h00);

    idle_until(2); drive(1, 1, R_CALL);
    drive(1, 0, 8'h00);
    for (int i = 0; i < 6; i++) drive(0, 0, 8'h00);
    drive(0, 0, R_INTR);
    idle_until(2); drive(0, 0, R_SEI);
    for (int i = 0; i < 4; i++) drive(0, 0, 8'h00);

    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 249) == 0);
      mid = $urandom_range(0, 1) == 1;
      req = 8'h00;
      for (int b = 1; b < 8; b++)
        if ($urandom_range(0, 4) == 0) req[b] = 1'b1;
      if ($urandom_range(0, 5) == 0) req[0] = 1'b1;
      if ($urandom_range(0, 1) == 0) req[6] = 1'b1;
      drive(r, mid, req);
    end
    drive(0, 0, 8'h00);

    repeat (3) @(posedge CLK);
    if (q_a.size() != 0 || q_b.size() != 0) begin
      failed++;
      $display("FAIL drain pending=%0d required=0", q_a.size() + q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
